// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with load-use bubble insertion, stall, flush
// and saturating bubble/flush counters.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3,
    parameter int PC_W   = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [9:0]        id_ctrl,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [RA_W-1:0]   id_rs_addr,
    input  logic [RA_W-1:0]   id_rt_addr,
    input  logic [RA_W-1:0]   id_rd_addr,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [9:0]        ex_ctrl,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RA_W-1:0]   ex_rs_addr,
    output logic [RA_W-1:0]   ex_rt_addr,
    output logic [RA_W-1:0]   ex_rd_addr,
    output logic              id_hold,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic ex_load, match, hazard, kill;
    assign ex_load = ex_valid & ex_ctrl[1] & ex_ctrl[0] & ~ex_ctrl[4];
    // register 0 is hardwired, so a zero destination can never create a dependency
    assign match   = (ex_rd_addr != '0) & ((id_rs_addr == ex_rd_addr) | (id_rt_addr == ex_rd_addr));
    assign hazard  = id_valid & ex_load & match & ~flush;
    assign id_hold = hazard | ex_stall;
    assign kill    = reset | flush | (~ex_stall & hazard);
    always_ff @(posedge clk) begin
        if (kill) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_pc      <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_rd_addr <= '0;
        end else if (!ex_stall) begin
            ex_valid   <= id_valid;
            ex_ctrl    <= id_valid ? id_ctrl : '0;
            ex_pc      <= id_pc;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs_addr <= id_rs_addr;
            ex_rt_addr <= id_rt_addr;
            ex_rd_addr <= id_rd_addr;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (flush && id_valid && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (hazard && !ex_stall && !(&bubble_cnt))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, counter saturation / reset sequences and random stimulus
// checked against a rule-level model of the decode/execute register.
module tb_id_ex_stage;
    localparam int CNT_W = 8;
    localparam int MAXC = (1 << CNT_W) - 1;
    localparam logic [9:0] LD  = 10'b1000000011;
    localparam logic [9:0] ADD = 10'b0000100001;
    localparam logic [9:0] ST  = 10'b0000010011;

    logic clk = 1'b0, reset, id_valid, ex_stall, flush;
    logic [9:0] id_ctrl;
    logic [15:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [2:0] id_rs_addr, id_rt_addr, id_rd_addr;
    logic ex_valid, id_hold;
    logic [9:0] ex_ctrl;
    logic [15:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [2:0] ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(16), .RA_W(3), .PC_W(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
        .id_hold(id_hold), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic v;
        logic [9:0] c;
        logic [15:0] pc, a, b, imm;
        logic [2:0] rs, rt, rd;
    } ex_t;

    typedef struct {
        logic r, v;
        logic [9:0] c;
        logic [2:0] rs, rt, rd;
        logic st, fl, eh, ev;
        logic [9:0] ec;
        int eb, ef;
    } vec_t;

    ex_t m;
    int bub = 0, fcnt = 0, checks = 0, errors = 0;

    function automatic int sat(input int x);
        return (x == MAXC) ? x : x + 1;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, act, exp);
        end
    endtask

    // one clock: drive, check combinational hold, advance the model, compare the whole ex stage
    task automatic step(input logic r, v, input logic [9:0] c, input logic [15:0] pc, a, b, imm,
                        input logic [2:0] rs, rt, rd, input logic st, fl, output logic h);
        logic is_load, dep, hz;
        reset = r; id_valid = v; id_ctrl = c; id_pc = pc; id_rs_data = a; id_rt_data = b;
        id_imm = imm; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd; ex_stall = st; flush = fl;
        #1;
        is_load = m.v && m.c[1] && m.c[0] && !m.c[4];
        dep = (m.rd != 0) && (rs == m.rd || rt == m.rd);
        hz = v && is_load && dep && !fl;
        h = id_hold;
        chk("id_hold", 64'(id_hold), 64'(hz || st));
        @(posedge clk);
        if (r) begin
            m = '0; bub = 0; fcnt = 0;
        end else if (fl) begin
            m = '0;
            if (v) fcnt = sat(fcnt);
        end else if (!st) begin
            if (hz) begin
                m = '0; bub = sat(bub);
            end else m = {v, v ? c : 10'd0, pc, a, b, imm, rs, rt, rd};
        end
        #1;
        chk("ex_valid", 64'(ex_valid), 64'(m.v));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(m.c));
        chk("ex_pc", 64'(ex_pc), 64'(m.pc));
        chk("ex_rs_data", 64'(ex_rs_data), 64'(m.a));
        chk("ex_rt_data", 64'(ex_rt_data), 64'(m.b));
        chk("ex_imm", 64'(ex_imm), 64'(m.imm));
        chk("ex_rs_addr", 64'(ex_rs_addr), 64'(m.rs));
        chk("ex_rt_addr", 64'(ex_rt_addr), 64'(m.rt));
        chk("ex_rd_addr", 64'(ex_rd_addr), 64'(m.rd));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(bub));
        chk("flush_cnt", 64'(flush_cnt), 64'(fcnt));
    endtask

    initial begin
        vec_t tv[$];
        logic h;
        m = '0;
        //        r     v     ctrl rs    rt    rd    st    fl    hold  valid ctrl bub fl
        tv.push_back('{1'b0, 1'b1, ADD, 3'd1, 3'd2, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, ADD, 0, 0});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd5, 3'd6, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, ADD, 0, 0});
        tv.push_back('{1'b0, 1'b1, 10'd0, 3'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 0, 0});
        tv.push_back('{1'b0, 1'b1, LD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, LD, 0, 0});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd3, 3'd1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 1, 0});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd3, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, ADD, 1, 0});
        tv.push_back('{1'b0, 1'b1, LD, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, LD, 1, 0});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, ADD, 1, 0});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd1, 3'd2, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, ADD, 1, 0});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd1, 3'd2, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, ADD, 1, 0});
        tv.push_back('{1'b0, 1'b1, LD, 3'd1, 3'd2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, LD, 1, 0});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd6, 3'd1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 1, 1});
        tv.push_back('{1'b0, 1'b1, LD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, LD, 1, 1});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd3, 3'd1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1, 2});
        tv.push_back('{1'b0, 1'b0, ADD, 3'd0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 1, 2});
        tv.push_back('{1'b0, 1'b0, ADD, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1, 2});
        tv.push_back('{1'b0, 1'b1, LD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, LD, 1, 2});
        tv.push_back('{1'b0, 1'b0, ADD, 3'd3, 3'd0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 1, 2});
        tv.push_back('{1'b0, 1'b1, LD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, LD, 1, 2});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, LD, 1, 2});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 2, 2});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, ADD, 2, 2});
        tv.push_back('{1'b0, 1'b1, ST, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, ST, 2, 2});
        tv.push_back('{1'b0, 1'b1, ADD, 3'd3, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, ADD, 2, 2});

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, h);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, h);
        chk("reset_valid", 64'(ex_valid), 64'(0));
        chk("reset_ctrl", 64'(ex_ctrl), 64'(0));
        chk("reset_pc", 64'(ex_pc), 64'(0));
        chk("reset_bub", 64'(bubble_cnt), 64'(0));
        chk("reset_flush", 64'(flush_cnt), 64'(0));

        foreach (tv[i]) begin
            step(tv[i].r, tv[i].v, tv[i].c, 16'h0100 + 16'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i),
                 16'h3000 + 16'(i), tv[i].rs, tv[i].rt, tv[i].rd, tv[i].st, tv[i].fl, h);
            chk($sformatf("row%0d_hold", i), 64'(h), 64'(tv[i].eh));
            chk($sformatf("row%0d_valid", i), 64'(ex_valid), 64'(tv[i].ev));
            chk($sformatf("row%0d_ctrl", i), 64'(ex_ctrl), 64'(tv[i].ec));
            chk($sformatf("row%0d_bub", i), 64'(bubble_cnt), 64'(tv[i].eb));
            chk($sformatf("row%0d_flush", i), 64'(flush_cnt), 64'(tv[i].ef));
        end

        // drive bubble_cnt up to one below all-ones, then three more hazards
        for (int k = 0; k < 600 && bub < MAXC - 1; k++) begin
            step(0, 1, LD, 16'h40, 16'h1, 16'h2, 16'h3, 3'd1, 3'd2, 3'd3, 0, 0, h);
            step(0, 1, ADD, 16'h44, 16'h4, 16'h5, 16'h6, 3'd3, 3'd2, 3'd4, 0, 0, h);
        end
        chk("bub_preload", 64'(bubble_cnt), 64'(MAXC - 1));
        for (int k = 0; k < 3; k++) begin
            step(0, 1, LD, 16'h40, 16'h1, 16'h2, 16'h3, 3'd1, 3'd2, 3'd3, 0, 0, h);
            step(0, 1, ADD, 16'h44, 16'h4, 16'h5, 16'h6, 3'd3, 3'd2, 3'd4, 0, 0, h);
            chk("bub_sat", 64'(bubble_cnt), 64'(MAXC));
        end
        for (int k = 0; k < MAXC + 2; k++)
            step(0, 1, ADD, 16'h50, 16'h1, 16'h2, 16'h3, 3'd1, 3'd2, 3'd3, k[0], 1, h);
        chk("flush_sat", 64'(flush_cnt), 64'(MAXC));

        step(0, 1, LD, 16'h60, 16'h7, 16'h8, 16'h9, 3'd1, 3'd2, 3'd3, 0, 0, h);
        step(1, 1, ADD, 16'h64, 16'h7, 16'h8, 16'h9, 3'd3, 3'd2, 3'd4, 0, 0, h);
        chk("rst_hz_hold", 64'(h), 64'(1));
        chk("rst_hz_all", {ex_valid, ex_ctrl, ex_pc, ex_rs_data, ex_rd_addr, bubble_cnt, flush_cnt}, 64'(0));
        step(0, 1, ADD, 16'h64, 16'h7, 16'h8, 16'h9, 3'd3, 3'd2, 3'd4, 1, 0, h);
        chk("rst_hold_stall", 64'(h), 64'(1));
        step(1, 1, ADD, 16'h68, 16'h7, 16'h8, 16'h9, 3'd3, 3'd2, 3'd4, 1, 0, h);
        chk("rst_stall_valid", 64'(ex_valid), 64'(0));
        step(0, 1, ADD, 16'h6c, 16'h7, 16'h8, 16'h9, 3'd0, 3'd0, 3'd4, 0, 0, h);
        chk("rst_hold_clear", 64'(h), 64'(0));

        for (int k = 0; k < 800; k++) begin
            logic [9:0] c;
            c = ($urandom_range(0, 2) == 0) ? 10'($urandom) : (($urandom_range(0, 1) == 1) ? LD : ADD);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0, c, 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), 3'($urandom),
                 3'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
